// File: rtl/mem_access_unit.sv
// MAR/MDR register pair with a req/ack memory transaction engine.
// Accepts read/write commands in IDLE and aborts a stalled request after TIMEOUT cycles.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_enable,
  input  logic              mdr_enable,
  input  logic              read,
  input  logic              write,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mar_data,
  output logic [DATA_W-1:0] mdr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              we_q;
  logic [CNT_W-1:0]  cnt;
  logic              done_q;
  logic              err_q;
  logic              start;
  logic              timeout_hit;

  always_comb begin
    state_n     = state;
    start       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (read || write) begin
          start   = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        // ack takes precedence over an expiring timeout on the same edge
        if (mem_ack) begin
          state_n = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == LAST)) begin
          timeout_hit = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar    <= '0;
      mdr    <= '0;
      we_q   <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == ACCESS) && (mem_ack || timeout_hit);
      case (state)
        IDLE: begin
          if (mar_enable) mar <= bus_in[ADDR_W-1:0];
          if (mdr_enable) mdr <= bus_in;
          if (start) begin
            we_q  <= ~read;
            err_q <= 1'b0;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) mdr <= mem_rdata;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == ACCESS);
  assign mem_req   = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && we_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mar_data  = mar;
  assign mdr_data  = mdr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected transactions,
// a negedge monitor checks request fields every request cycle and results on done.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_in;
  logic        mar_enable, mdr_enable, read, write;
  logic        busy, done, err;
  logic [8:0]  mar_data;
  logic [31:0] mdr_data;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] mdr;
    int          cycles;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  mem_access_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_in    (bus_in),
    .mar_enable(mar_enable),
    .mdr_enable(mdr_enable),
    .read      (read),
    .write     (write),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mar_data  (mar_data),
    .mdr_data  (mdr_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: request-cycle field checks and completion checks against the queue head
  initial begin
    int   rc;
    exp_t e;
    rc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rc = 0;
      end else begin
        if (mem_req) begin
          if (sb.size() == 0) begin
            check("req_without_cmd", 32'(mem_req), 32'd0);
          end else begin
            check("req_we", 32'(mem_we), 32'(sb[0].we));
            check("req_addr", 32'(mem_addr), 32'(sb[0].addr));
            check("req_wdata", mem_wdata, sb[0].wdata);
          end
          rc++;
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            check("done_err", 32'(err), 32'(e.err));
            check("done_mdr", mdr_data, e.mdr);
            check("req_cycles", 32'(rc), 32'(e.cycles));
            check("done_busy", 32'(busy), 32'd0);
          end
          rc = 0;
        end
      end
    end
  end

  task automatic load(input logic lm, input logic ld, input logic [31:0] v);
    @(negedge clk);
    mar_enable = lm;
    mdr_enable = ld;
    bus_in     = v;
    @(posedge clk);
    #1;
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
  endtask

  // ack_at = n acks on the n-th request cycle; 0 never acks
  task automatic run_cmd(input logic rd, input logic wr, input int ack_at,
                         input logic [31:0] rdata, input logic poke, input exp_t e);
    int n;
    @(negedge clk);
    read  = rd;
    write = wr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    read       = 1'b0;
    write      = 1'b0;
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
      mem_ack   = (n == ack_at);
      mem_rdata = (n == ack_at) ? rdata : 32'h5A5A_0000 + 32'(n);
      if (poke) begin
        mdr_enable = 1'b1;
        mar_enable = 1'b1;
        bus_in     = 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      mem_ack    = 1'b0;
      mdr_enable = 1'b0;
      mar_enable = 1'b0;
    end
    if (n >= 40) check("cmd_completion_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    bus_in     = '0;
    mar_enable = 1'b0;
    mdr_enable = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mar", 32'(mar_data), 32'd0);
    check("rst_mdr", mdr_data, 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // read, ack on 3rd request cycle
    load(1'b1, 1'b0, 32'h0000_0005);
    check("mar_load", 32'(mar_data), 32'h005);
    run_cmd(1'b1, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, '{1'b0, 32'hDEAD_BEEF, 3, 1'b0, 9'h005, 32'h0});

    // write, immediate ack
    load(1'b1, 1'b0, 32'h0000_01FF);
    load(1'b0, 1'b1, 32'h1234_5678);
    run_cmd(1'b0, 1'b1, 1, 32'hFFFF_0000, 1'b0, '{1'b0, 32'h1234_5678, 1, 1'b1, 9'h1FF, 32'h1234_5678});

    // timeout, then back-to-back read that clears err
    run_cmd(1'b1, 1'b0, 0, 32'h0, 1'b0, '{1'b1, 32'h1234_5678, 15, 1'b0, 9'h1FF, 32'h1234_5678});
    run_cmd(1'b1, 1'b0, 2, 32'hA5A5_A5A5, 1'b0, '{1'b0, 32'hA5A5_A5A5, 2, 1'b0, 9'h1FF, 32'h1234_5678});

    // read and write together issue a read
    run_cmd(1'b1, 1'b1, 1, 32'h0BAD_F00D, 1'b0, '{1'b0, 32'h0BAD_F00D, 1, 1'b0, 9'h1FF, 32'hA5A5_A5A5});

    // ack on the timeout edge wins
    run_cmd(1'b1, 1'b0, 15, 32'h7777_7777, 1'b0, '{1'b0, 32'h7777_7777, 15, 1'b0, 9'h1FF, 32'h0BAD_F00D});

    // MAR/MDR loads ignored during ACCESS
    run_cmd(1'b0, 1'b1, 4, 32'h0, 1'b1, '{1'b0, 32'h7777_7777, 4, 1'b1, 9'h1FF, 32'h7777_7777});
    #1;
    check("mar_after_poke", 32'(mar_data), 32'h1FF);

    // MAR load on the same edge as the command
    @(negedge clk);
    mar_enable = 1'b1;
    bus_in     = 32'h0000_00AB;
    run_cmd(1'b1, 1'b0, 2, 32'h1357_9BDF, 1'b0, '{1'b0, 32'h1357_9BDF, 2, 1'b0, 9'h0AB, 32'h7777_7777});

    // stray ack in IDLE
    repeat (2) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hEEEE_EEEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ack_done", 32'(done), 32'd0);
      check("stray_ack_busy", 32'(busy), 32'd0);
    end
    mem_ack = 1'b0;
    check("stray_ack_mdr", mdr_data, 32'h1357_9BDF);

    // reset in the 2nd ACCESS cycle
    @(negedge clk);
    read = 1'b1;
    sb.push_back('{1'b0, 32'h0, 0, 1'b0, 9'h0AB, 32'h1357_9BDF});
    @(posedge clk);
    #1;
    read = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mar", 32'(mar_data), 32'd0);
    check("midrst_mdr", mdr_data, 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    load(1'b1, 1'b0, 32'h0000_0003);
    run_cmd(1'b1, 1'b0, 2, 32'hCAFE_F00D, 1'b0, '{1'b0, 32'hCAFE_F00D, 2, 1'b0, 9'h003, 32'h0});

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access block replacing the separate MAR, MDR, MDR input mux and single-cycle RAM hookup in the CPU datapath. It owns the MAR and MDR registers, loads them from the bus, and runs read/write transactions to an external memory over a req/ack handshake. Memory latency may vary, and a configurable timeout aborts stalled accesses. The control unit starts commands with `read`/`write` and holds its step sequence while `busy` is high.

## Interface
- DATA_W, 32, data / MDR width
- ADDR_W, 9, address / MAR width; MAR loads from bus_in[ADDR_W-1:0]
- TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before abort; 0 disables the timeout
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- bus_in  in  DATA_W  datapath bus
- mar_enable  in  1  load MAR from bus_in (IDLE only)
- mdr_enable  in  1  load MDR from bus_in (IDLE only)
- read  in  1  start read: MDR <= mem[MAR]
- write  in  1  start write: mem[MAR] <= MDR
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  last transaction timed out; sticky until next command accepted
- mar_data  out  ADDR_W  MAR contents
- mdr_data  out  DATA_W  MDR contents, drives bus mux
- mem_req  out  1  request to memory
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  equals MAR
- mem_wdata  out  DATA_W  equals MDR
- mem_ack  in  1  memory completion; read data valid same cycle
- mem_rdata  in  DATA_W  read data

## Operation
- States: IDLE, ACCESS. busy = mem_req = (state == ACCESS).
- **IDLE:**
  - mar_enable loads MAR and mdr_enable loads MDR.
  - If read or write is sampled high:
    - latch op: read has priority when both are high, and the write is dropped;
    - clear err;
    - clear the wait counter;
    - go to ACCESS.
  - A load and a command on the same edge are legal. The request uses the newly loaded MAR/MDR.
- **ACCESS:**
  - mem_we = latched op; mem_addr and mem_wdata are stable.
  - mar_enable, mdr_enable, read and write are ignored.
  - On mem_ack at an edge:
    - if read, MDR <= mem_rdata;
    - done <= 1;
    - go to IDLE.
  - Without mem_ack: counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1:
    - err <= 1;
    - done <= 1;
    - MDR unchanged;
    - go to IDLE.
  - mem_ack and timeout on the same edge: ack wins, and err stays 0.
- mem_ack sampled in IDLE is ignored.
- done is registered and high for exactly the one cycle after the completing edge.
- Counter width: clog2(TIMEOUT+1), minimum 1 bit. It saturates when TIMEOUT = 0.

## Timing
- **Reset values:** state IDLE; MAR 0; MDR 0; busy 0; done 0; err 0; mem_req 0; mem_we 0. mem_addr and mem_wdata are 0 because they follow MAR/MDR.
- **Reset mid-access:** mem_req drops asynchronously. No done pulse is produced, and the memory must discard the request.
- **Command timing:** a command sampled at edge k gives mem_req high from edge k.
- **Completion timing:** mem_ack sampled at edge k+n (n ≥ 1) gives:
  - busy low after edge k+n;
  - done high for cycle k+n..k+n+1;
  - MDR updated after edge k+n.
- **Minimum:** 1 cycle of mem_req, with done one cycle after the command edge.
- **Back-to-back:** a new command may be sampled on the edge where done is high, i.e. the cycle after the previous completion. There is no dead cycle beyond done.
- **Timeout:** mem_req is high for exactly TIMEOUT cycles when no ack arrives.

## Test plan
- **Read, fixed latency:**
  - Stimulus: MAR=0x05 via bus; read; memory acks with 0xDEADBEEF on the 3rd request cycle.
  - Response: mem_req high 3 cycles with mem_we=0 and mem_addr=0x05; then done pulse, mdr_data=0xDEADBEEF, err=0.
- **Write, immediate ack:**
  - Stimulus: MAR=0x1FF, MDR=0x12345678; write; mem_ack on the first cycle.
  - Response: one request cycle with mem_we=1, mem_wdata=0x12345678; done the next cycle; MDR unchanged.
- **Timeout:**
  - Stimulus: TIMEOUT=15; read with no ack.
  - Response: mem_req high exactly 15 cycles; done pulse; err=1; MDR keeps its old value. A following read acked normally clears err.
- **Simultaneous events:**
  - read+write together: a read is issued.
  - mem_ack on the timeout edge: err=0.
  - mdr_enable during ACCESS with bus=0xFFFFFFFF: MDR unaffected.
  - Stray mem_ack in IDLE: no done pulse.
- **Reset mid-access:**
  - Stimulus: reset asserted in the 2nd ACCESS cycle, off-edge.
  - Response: mem_req, busy, MAR and MDR all 0 immediately; no done pulse; next read proceeds normally.
